// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Parametrised inter-stage pipeline register. Carries a
//                WIDTH-bit payload through DEPTH register slices, each with
//                its own valid bit. Supports stall (hold every slice) and
//                flush (kill every slice). The low CTRL_W payload bits are
//                control signals and are forced to zero for every bubble.
//  Parameters  : WIDTH  (1..256) payload width
//                DEPTH  (1..8)   number of slices = latency in cycles
//                CTRL_W (0..WIDTH) low control bits zeroed on bubble/flush
//  Ports       : clk        rising-edge clock
//                reset      asynchronous active-low reset
//                in_valid   upstream payload is a real instruction
//                in_data    upstream payload
//                stall      hold every slice, drop in_data
//                flush      invalidate every slice, zero control bits
//                out_valid  valid bit of the last slice
//                out_data   payload of the last slice
//                stall_cnt  saturating stall-cycle counter   (perf build)
//                bubble_cnt saturating bubble-cycle counter  (perf build)
//  Macro       : PIPE_STAGE_PERF_EN adds stall_cnt / bubble_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 1,
  parameter int CTRL_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      bubble_cnt
`endif
);

  // Legal-range checks, evaluated at elaboration.
  generate
    if (WIDTH < 1 || WIDTH > 256) begin : g_bad_width
      $error("pipe_stage_reg: WIDTH must be in 1..256");
    end
    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
      $error("pipe_stage_reg: DEPTH must be in 1..8");
    end
    if (CTRL_W < 0 || CTRL_W > WIDTH) begin : g_bad_ctrl_w
      $error("pipe_stage_reg: CTRL_W must be in 0..WIDTH");
    end
  endgenerate

  // Ones in the control-bit positions. CTRL_W=0 shifts everything out,
  // giving an all-zero mask so nothing is ever forced low.
  localparam logic [WIDTH-1:0] c_ctrl_mask = {WIDTH{1'b1}} >> (WIDTH - CTRL_W);

  logic             r_valid    [DEPTH];
  logic [WIDTH-1:0] r_data     [DEPTH];
  logic             w_src_valid[DEPTH];
  logic [WIDTH-1:0] w_src_data [DEPTH];
  logic [WIDTH-1:0] w_capture_data;

  // A bubble entering slice0 must not carry live control bits; the upper
  // bits are don't-care and are taken as presented.
  assign w_capture_data = in_valid ? in_data : (in_data & ~c_ctrl_mask);

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_slice
      // Source of each slice on an advance: the input for slice0,
      // otherwise the preceding slice.
      if (i == 0) begin : g_head
        assign w_src_valid[i] = in_valid;
        assign w_src_data[i]  = w_capture_data;
      end else begin : g_tail
        assign w_src_valid[i] = r_valid[i-1];
        assign w_src_data[i]  = r_data[i-1];
      end

      // flush beats stall beats advance.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_valid[i] <= 1'b0;
          r_data[i]  <= '0;
        end else if (flush) begin
          r_valid[i] <= 1'b0;
          r_data[i]  <= r_data[i] & ~c_ctrl_mask;
        end else if (!stall) begin
          r_valid[i] <= w_src_valid[i];
          r_data[i]  <= w_src_data[i];
        end
      end
    end
  endgenerate

  // Outputs come straight from the last slice: no input-to-output path.
  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  // Both counters saturate at all-ones; only reset brings them back to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (stall && !flush && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (!r_valid[DEPTH-1] && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire
